// File: rtl/spikehard_router_pkg.sv
// -----------------------------------------------------------------------------
// spikehard_router_pkg
// Shared definitions for the spike-packet router: output port indices, routing
// stage FSM encodings and the default packet field widths.
// -----------------------------------------------------------------------------
package spikehard_router_pkg;

    // Output port indices; bit order of every per-port vector is {L, S, N, W, E}
    localparam int PORT_E    = 0;
    localparam int PORT_W    = 1;
    localparam int PORT_N    = 2;
    localparam int PORT_S    = 3;
    localparam int PORT_L    = 4;
    localparam int NUM_PORTS = 5;

    // Default packet field widths
    localparam int DEF_DX_WIDTH      = 9;
    localparam int DEF_DY_WIDTH      = 9;
    localparam int DEF_PAYLOAD_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/packet_route_decode.sv
// -----------------------------------------------------------------------------
// packet_route_decode
// Purely combinational hop decision for one packet {dx, dy, payload}.
// Picks the output port (priority: dx first, then dy, else local) and steps the
// chosen offset one hop toward zero. Payload and the other offset pass through.
//
// Ports:
//   pkt      in   packet to route
//   sel      out  one-hot port select, {L, S, N, W, E}
//   stepped  out  packet with the travelled offset stepped toward zero
// -----------------------------------------------------------------------------
module packet_route_decode
    import spikehard_router_pkg::*;
#(
    parameter  int DX_WIDTH      = DEF_DX_WIDTH,
    parameter  int DY_WIDTH      = DEF_DY_WIDTH,
    parameter  int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
    localparam int PACKET_WIDTH  = DX_WIDTH + DY_WIDTH + PAYLOAD_WIDTH
) (
    input  logic [PACKET_WIDTH-1:0] pkt,
    output logic [NUM_PORTS-1:0]    sel,
    output logic [PACKET_WIDTH-1:0] stepped
);

    localparam logic signed [DX_WIDTH-1:0] DX_ONE = DX_WIDTH'(1);
    localparam logic signed [DY_WIDTH-1:0] DY_ONE = DY_WIDTH'(1);

    logic signed [DX_WIDTH-1:0] dx;
    logic signed [DX_WIDTH-1:0] dx_out;
    logic signed [DY_WIDTH-1:0] dy;
    logic signed [DY_WIDTH-1:0] dy_out;
    logic [PAYLOAD_WIDTH-1:0]   payload;
    logic                       dx_zero;
    logic                       dy_zero;

    // Stepping is always toward zero, so a field-width add/sub never overflows
    function automatic logic signed [DX_WIDTH-1:0] step_dx(input logic signed [DX_WIDTH-1:0] v);
        return v[DX_WIDTH-1] ? v + DX_ONE : v - DX_ONE;
    endfunction

    function automatic logic signed [DY_WIDTH-1:0] step_dy(input logic signed [DY_WIDTH-1:0] v);
        return v[DY_WIDTH-1] ? v + DY_ONE : v - DY_ONE;
    endfunction

    assign dx      = pkt[PACKET_WIDTH-1 -: DX_WIDTH];
    assign dy      = pkt[PAYLOAD_WIDTH +: DY_WIDTH];
    assign payload = pkt[PAYLOAD_WIDTH-1:0];
    assign dx_zero = (dx == '0);
    assign dy_zero = (dy == '0);

    always_comb begin
        sel    = '0;
        dx_out = dx;
        dy_out = dy;
        if (!dx_zero) begin
            sel[dx[DX_WIDTH-1] ? PORT_W : PORT_E] = 1'b1;
            dx_out = step_dx(dx);
        end else if (!dy_zero) begin
            sel[dy[DY_WIDTH-1] ? PORT_S : PORT_N] = 1'b1;
            dy_out = step_dy(dy);
        end else begin
            sel[PORT_L] = 1'b1;
        end
    end

    assign stepped = {dx_out, dy_out, payload};

endmodule

// File: rtl/packet_route_stage.sv
// -----------------------------------------------------------------------------
// packet_route_stage
// Drains one upstream buffer (registered read, one-cycle latency), routes each
// packet one hop and holds it on exactly one of five valid/ready outputs.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   fifo_dout       upstream data, valid the cycle after fifo_read_en
//   fifo_empty      upstream buffer empty
//   fifo_read_en    pop request (combinational)
//   out_data        forwarded packet {dx, dy, payload}
//   out_valid       one-hot valid {L, S, N, W, E}
//   out_ready       per-port ready, same bit order
//   busy            high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module packet_route_stage
    import spikehard_router_pkg::*;
#(
    parameter  int DX_WIDTH      = DEF_DX_WIDTH,
    parameter  int DY_WIDTH      = DEF_DY_WIDTH,
    parameter  int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
    localparam int PACKET_WIDTH  = DX_WIDTH + DY_WIDTH + PAYLOAD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKET_WIDTH-1:0] fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_read_en,
    output logic [PACKET_WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]    out_valid,
    input  logic [NUM_PORTS-1:0]    out_ready,
    output logic                    busy
);

    state_t                  state;
    state_t                  next_state;
    logic                    load;
    logic                    accept;
    logic [NUM_PORTS-1:0]    sel_p0;
    logic [PACKET_WIDTH-1:0] stepped_p0;
    logic [NUM_PORTS-1:0]    vld_p1;
    logic [PACKET_WIDTH-1:0] data_p1;

    // Stage 0: decode the word returned by the buffer
    packet_route_decode #(
        .DX_WIDTH      (DX_WIDTH),
        .DY_WIDTH      (DY_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
    ) u_decode (
        .pkt     (fifo_dout),
        .sel     (sel_p0),
        .stepped (stepped_p0)
    );

    // vld_p1 is one-hot while in SEND, so any overlap with ready is the handshake
    assign accept = (state == ST_SEND) && ((vld_p1 & out_ready) != '0);

    always_comb begin
        next_state   = state;
        fifo_read_en = 1'b0;
        load         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_read_en = 1'b1;
                    next_state   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                load       = 1'b1;
                next_state = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    // Pop the next packet in the accept cycle to keep 2-cycle spacing
                    if (!fifo_empty) begin
                        fifo_read_en = 1'b1;
                        next_state   = ST_FETCH;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (!rst) begin
            fifo_read_en = 1'b0;
        end
    end

    // Stage 1: output register, held stable until the selected port accepts
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            vld_p1  <= '0;
            data_p1 <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                vld_p1  <= sel_p0;
                data_p1 <= stepped_p0;
            end else if (accept) begin
                vld_p1  <= '0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/packet_route_stage.md
# packet_route_stage

Single-input routing stage for spike packets. It drains one `fifo_buffer` instance and decodes the packet's relative destination `(dx, dy)`. It then steps the packet one hop toward its destination and presents it on exactly one of five outputs: east, west, north, south or local, each with a valid/ready handshake. It sits directly downstream of each router input buffer and hides that buffer's one-cycle registered read latency from the merge logic further on.

## Interface
Parameters:
- `DX_WIDTH`, 9, width of signed two's-complement dx field.
- `DY_WIDTH`, 9, width of signed two's-complement dy field.
- `PAYLOAD_WIDTH`, 12, width of payload (axon index and tick bits).
- `PACKET_WIDTH`, `DX_WIDTH+DY_WIDTH+PAYLOAD_WIDTH`, derived, not overridden.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `fifo_dout`  in  PACKET_WIDTH  upstream buffer data, valid the cycle after `fifo_read_en`.
- `fifo_empty`  in  1  upstream buffer empty.
- `fifo_read_en`  out  1  pop request to upstream buffer.
- `out_data`  out  PACKET_WIDTH  forwarded packet, packed `{dx, dy, payload}`, MSB first.
- `out_valid`  out  5  one-hot valid, bit order `[4:0] = {L, S, N, W, E}`.
- `out_ready`  in  5  per-port ready, same bit order.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: `fifo_read_en = !fifo_empty`. If it is asserted, go to FETCH.
  - FETCH: `fifo_dout` is valid. Decode it, load the output register, go to SEND.
  - SEND: hold the output until the selected port's ready is sampled high.
- Routing decision, evaluated in priority order:
  - dx > 0: port E, dx_out = dx − 1.
  - dx < 0: port W, dx_out = dx + 1.
  - dx == 0, dy > 0: port N, dy_out = dy − 1.
  - dx == 0, dy < 0: port S, dy_out = dy + 1.
  - dx == 0, dy == 0: port L, packet unmodified.
- Only the field being stepped changes. Payload always passes through unchanged.
- dx/dy arithmetic is at field width. No overflow is possible because the step is always toward zero.
- SEND exit when `out_ready[sel]` is high:
  - If `fifo_empty` is low: assert `fifo_read_en` in that same cycle and go to FETCH.
  - Otherwise go to IDLE.
- `fifo_read_en` is a combinational output. It is never asserted in FETCH, never asserted in SEND unless the handshake completes that cycle, and never asserted when `fifo_empty` is high.
- Ready on non-selected ports is ignored.
- `out_valid` has at most one bit set. It is zero outside SEND.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `busy = 0`, state IDLE. `fifo_read_en` is 0 while `rst` is low.
- Reset mid-operation returns the FSM to IDLE next edge. A packet already popped and not yet accepted is discarded. The upstream buffer resets on the same `rst`.
- Latency: pop in cycle t → `fifo_dout` valid in t+1 → `out_valid` high from t+2.
- Throughput: at most 1 packet per 2 cycles with ready held high.
- `out_data` and `out_valid` are registered and stay stable throughout SEND, including while ready is low.
- Ready may be asserted before valid. Acceptance is the cycle where both are high on the selected port.

## Structure
- Package `spikehard_router_pkg` holds:
  - port index constants `PORT_E=0, PORT_W=1, PORT_N=2, PORT_S=3, PORT_L=4`, and `NUM_PORTS=5`;
  - state encodings `ST_IDLE`, `ST_FETCH`, `ST_SEND`;
  - default field widths.
- One sub-module: `packet_route_decode`, purely combinational. It takes a packet and returns a one-hot port select and the stepped packet. It is reused by the merge stage for lookahead.

## Test plan
- dx=+3, dy=−2, payload=0x0A5, out_ready=all 1 → `out_valid=5'b00001`, out dx=+2, dy=−2, payload 0x0A5, valid 2 cycles after pop.
- dx=0, dy=−1 → port S (`5'b01000`), dy=0. Second packet dx=0, dy=0 → port L (`5'b10000`), data bit-identical to input.
- dx=−1, out_ready[W] held low 10 cycles → `out_valid=5'b00010` and data stable for 10 cycles, no `fifo_read_en`. Raise ready → accepted, next pop the same cycle if `fifo_empty` is low.
- Buffer preloaded with 4 packets, all ready high → `fifo_read_en` pulses every 2nd cycle, 4 packets out in 8 cycles, FSM returns to IDLE, `busy` goes low.
- `rst` low during SEND → next edge `out_valid=0`, state IDLE. After release, behaviour is normal on fresh input.
- dx=−256 (min at 9 bits) → port W, dx=−255; dx=+255 → port E, dx=+254.
